// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU control codes, ALUOp encodings, funct3 values.
package riscv_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned FUNCT3_W   = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALUOP_LS    = 2'b00,
        ALUOP_BR    = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_NOR   = 2'b11
    } alu_op_e;

    localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;

    // Decoded ALU control payload carried into the ID/EX register
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  illegal;
    } alu_dec_t;

endpackage

// File: rtl/riscv_alu_ctrl.sv
// Combinational ALU control decoder: ALUOp/funct3/bit30/alu_src -> {ainvert, bnegate, op}.
module riscv_alu_ctrl
    import riscv_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7_5,
    input  logic                  alu_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_c,
    output logic                  illegal_c
);

    // Decode ALUOp first, then funct3 for R/I-type arithmetic
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        illegal_c  = 1'b0;
        case (alu_op)
            ALUOP_LS:  alu_ctrl_c = ALU_ADD;
            ALUOP_BR:  alu_ctrl_c = ALU_SUB;
            ALUOP_NOR: alu_ctrl_c = ALU_NOR;
            default: begin
                case (funct3)
                    // bit 30 only selects sub for register-register forms
                    F3_ADD_SUB: alu_ctrl_c = (funct7_5 & ~alu_src) ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_ctrl_c = ALU_AND;
                    F3_OR:      alu_ctrl_c = ALU_OR;
                    F3_SLT:     alu_ctrl_c = ALU_SLT;
                    default: begin
                        alu_ctrl_c = ALU_AND;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/riscv_id_ex.sv
// ID/EX pipeline register: ALU control decode, B-operand select, single-entry
// valid/ready output register with flush.
// Optional feature macro: RISCV_IDEX_PERF_EN adds saturating stall/flush counters.
module riscv_id_ex
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_pc,
    input  logic [WIDTH-1:0]      in_rs1_data,
    input  logic [WIDTH-1:0]      in_rs2_data,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    input  logic [FUNCT3_W-1:0]   in_funct3,
    input  logic                  in_funct7_5,
    input  logic                  in_alu_src,
    input  logic                  in_reg_write,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
    output logic                  out_illegal,
    output logic [WIDTH-1:0]      out_rs2_data,
    output logic [WIDTH-1:0]      out_pc,
    output logic [REG_AW-1:0]     out_rd,
    output logic                  out_reg_write
`ifdef RISCV_IDEX_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count
`endif
);

    alu_dec_t   dec;
    logic       load;

    riscv_alu_ctrl u_alu_ctrl (
        .alu_op     (in_alu_op),
        .funct3     (in_funct3),
        .funct7_5   (in_funct7_5),
        .alu_src    (in_alu_src),
        .alu_ctrl_c (dec.alu_ctrl),
        .illegal_c  (dec.illegal)
    );

    // Ready whenever the slot is empty or being drained this cycle
    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    // Valid bit: flush > load > drain > hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on a load, so held entries stay bit-stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a         <= '0;
            out_b         <= '0;
            out_alu_ctrl  <= '0;
            out_illegal   <= 1'b0;
            out_rs2_data  <= '0;
            out_pc        <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (load) begin
            out_a         <= in_rs1_data;
            out_b         <= in_alu_src ? in_imm : in_rs2_data;
            out_alu_ctrl  <= dec.alu_ctrl;
            out_illegal   <= dec.illegal;
            out_rs2_data  <= in_rs2_data;
            out_pc        <= in_pc;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
        end
    end

`ifdef RISCV_IDEX_PERF_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (out_valid && !out_ready && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush && (out_valid || in_valid) && perf_flush_count != 32'hFFFF_FFFF) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_id_ex.sv
// Self-checking bench for riscv_id_ex: decode table, handshake corner sequences,
// randomized traffic against a transaction-level model.
module tb_riscv_id_ex;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_alu_op;
    logic [2:0]        in_funct3;
    logic              in_funct7_5, in_alu_src, in_reg_write;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_a, out_b, out_rs2_data, out_pc;
    logic [3:0]        out_alu_ctrl;
    logic              out_illegal;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
`ifdef RISCV_IDEX_PERF_EN
    logic [31:0]       perf_stall_cycles, perf_flush_count;
`endif

    int checks = 0;
    int errors = 0;

    riscv_id_ex #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_rd         (in_rd),
        .in_alu_op     (in_alu_op),
        .in_funct3     (in_funct3),
        .in_funct7_5   (in_funct7_5),
        .in_alu_src    (in_alu_src),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_alu_ctrl  (out_alu_ctrl),
        .out_illegal   (out_illegal),
        .out_rs2_data  (out_rs2_data),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef RISCV_IDEX_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU control from the instruction-level meaning of each encoding
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f75, input logic src);
        logic [3:0] c;
        logic       ill;
        ill = 1'b0;
        if (op == 2'b00)      c = 4'b0010;           // load/store address add
        else if (op == 2'b01) c = 4'b0110;           // branch compare subtract
        else if (op == 2'b11) c = 4'b1100;           // nor
        else if (f3 == 3'b000) c = (f75 && !src) ? 4'b0110 : 4'b0010;
        else if (f3 == 3'b111) c = 4'b0000;
        else if (f3 == 3'b110) c = 4'b0001;
        else if (f3 == 3'b010) c = 4'b0111;
        else begin c = 4'b0000; ill = 1'b1; end
        return {c, ill};
    endfunction

    task automatic offer(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                         input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        in_valid     = 1'b1;
        in_alu_op    = op;
        in_funct3    = f3;
        in_funct7_5  = f75;
        in_alu_src   = src;
        in_rs1_data  = rs1;
        in_rs2_data  = rs2;
        in_imm       = imm;
        in_pc        = pc;
        in_rd        = pc[4:0];
        in_reg_write = pc[0];
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0;
        in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_rd = '0;
        in_alu_op = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_alu_src = 1'b0;
        in_reg_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       src;
        logic [3:0] ctrl;
        logic       ill;
    } dec_vec_t;

    typedef struct {
        logic [31:0] pc, a, b, rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [3:0]  ctrl;
        logic        ill;
    } entry_t;

    dec_vec_t vecs[12];
    entry_t   m_entry;
    logic     m_valid;

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        idle_inputs();

        vecs[0]  = '{2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0};
        vecs[1]  = '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[2]  = '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0010, 1'b0};
        vecs[3]  = '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[4]  = '{2'b10, 3'b110, 1'b0, 1'b1, 4'b0001, 1'b0};
        vecs[5]  = '{2'b10, 3'b010, 1'b1, 1'b0, 4'b0111, 1'b0};
        vecs[6]  = '{2'b10, 3'b001, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[7]  = '{2'b10, 3'b101, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[8]  = '{2'b11, 3'b001, 1'b0, 1'b0, 4'b1100, 1'b0};
        vecs[9]  = '{2'b01, 3'b001, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[10] = '{2'b00, 3'b010, 1'b0, 1'b1, 4'b0010, 1'b0};
        vecs[11] = '{2'b10, 3'b100, 1'b0, 1'b1, 4'b0000, 1'b1};

        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_ctrl", 32'(out_alu_ctrl), 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

`ifdef RISCV_IDEX_PERF_EN
        // Three stall cycles then two flush events
        check("perf_rst_stall", perf_stall_cycles, 32'd0);
        check("perf_rst_flush", perf_flush_count, 32'd0);
        @(negedge clk);
        offer(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'h40);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        offer(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'h44);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("perf_stall_3", perf_stall_cycles, 32'd3);
        check("perf_flush_2", perf_flush_count, 32'd2);
        offer(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'h48);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("perf_async_stall", perf_stall_cycles, 32'd0);
        check("perf_async_flush", perf_flush_count, 32'd0);
        check("perf_async_valid", 32'(out_valid), 32'd0);
        do_reset();
`endif

        // Decode table, one instruction per cycle with the consumer always ready
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            offer(vecs[i].op, vecs[i].f3, vecs[i].f75, vecs[i].src,
                  32'd5 + 32'(i), 32'd7, 32'hFFFF_FFFF, 32'h100 + 32'(i * 4));
            @(posedge clk);
            #1;
            check($sformatf("dec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("dec%0d_ctrl", i), 32'(out_alu_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("dec%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
            check($sformatf("dec%0d_a", i), out_a, 32'd5 + 32'(i));
            check($sformatf("dec%0d_b", i), out_b, vecs[i].src ? 32'hFFFF_FFFF : 32'd7);
        end

        // Backpressure: 4 stall cycles with a pending offer, then no-bubble replace
        @(negedge clk);
        offer(2'b10, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h200);
        @(negedge clk);
        out_ready = 1'b0;
        offer(2'b10, 3'b000, 1'b1, 1'b0, 32'd9, 32'd3, 32'd0, 32'h204);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_pc", c), out_pc, 32'h200);
            check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_ctrl", c), 32'(out_alu_ctrl), 32'b0010);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("replace_valid", 32'(out_valid), 32'd1);
        check("replace_pc", out_pc, 32'h204);
        check("replace_ctrl", 32'(out_alu_ctrl), 32'b0110);

        // Flush with a held entry and a simultaneous offer
        @(negedge clk);
        out_ready = 1'b0;
        offer(2'b10, 3'b111, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h300);
        flush = 1'b1;
        #1 check("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_flush%0d_valid", c), 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-stall, then load on first edge after release
        out_ready = 1'b1;
        offer(2'b11, 3'b000, 1'b0, 1'b0, 32'd8, 32'd8, 32'd0, 32'h400);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ctrl", 32'(out_alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(2'b01, 3'b000, 1'b0, 1'b0, 32'd8, 32'd8, 32'd0, 32'h404);
        @(posedge clk);
        #1;
        check("first_load_valid", 32'(out_valid), 32'd1);
        check("first_load_pc", out_pc, 32'h404);

        // Randomized traffic against a transaction model
        do_reset();
        m_valid = 1'b0;
        m_entry = '{default: '0};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (m_valid !== out_valid) begin
                check("rnd_valid", 32'(out_valid), 32'(m_valid));
            end else if (m_valid) begin
                check("rnd_pc", out_pc, m_entry.pc);
                check("rnd_a", out_a, m_entry.a);
                check("rnd_b", out_b, m_entry.b);
                check("rnd_rs2", out_rs2_data, m_entry.rs2);
                check("rnd_ctrl", {27'd0, out_alu_ctrl, out_illegal}, {27'd0, m_entry.ctrl, m_entry.ill});
                check("rnd_rd_rw", {26'd0, out_rd, out_reg_write}, {26'd0, m_entry.rd, m_entry.rw});
            end
            offer(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 32'(cyc) << 2);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            if (in_ready !== (!m_valid || out_ready))
                check("rnd_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            // Slot is free if empty or consumed; flush discards both slot and offer
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                logic [4:0] d;
                d = ref_dec(in_alu_op, in_funct3, in_funct7_5, in_alu_src);
                m_valid = 1'b1;
                m_entry.pc   = in_pc;
                m_entry.a    = in_rs1_data;
                m_entry.b    = in_alu_src ? in_imm : in_rs2_data;
                m_entry.rs2  = in_rs2_data;
                m_entry.rd   = in_rd;
                m_entry.rw   = in_reg_write;
                m_entry.ctrl = d[4:1];
                m_entry.ill  = d[0];
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
